// File: rtl/byte_demux_pkg.sv
// Shared widths and channel index type for the two-way byte demultiplexer.
package byte_demux_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

endpackage

// File: rtl/byte_fifo2.sv
// DEPTH-entry first-in first-out byte buffer; head entry is presented directly.
module byte_fifo2 #(
    parameter int unsigned DATA_W = byte_demux_pkg::DATA_W,
    parameter int unsigned DEPTH  = byte_demux_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle never frees room for a push into a full buffer.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/byte_demux2.sv
// Routes each accepted byte to one of two buffered channels, by select or alternating toggle.
module byte_demux2
    import byte_demux_pkg::*;
#(
    parameter int unsigned DATA_W = byte_demux_pkg::DATA_W,
    parameter int unsigned DEPTH  = byte_demux_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              auto_mode,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    chan_e dst;
    logic  tgl;
    logic  accept;
    logic  push0;
    logic  push1;
    logic  full0;
    logic  full1;
    logic  empty0;
    logic  empty1;

    assign dst        = auto_mode ? chan_e'(tgl) : chan_e'(in_sel);
    assign in_ready   = (dst == CH0) ? ~full0 : ~full1;
    assign accept     = in_valid & in_ready;
    assign push0      = accept & (dst == CH0);
    assign push1      = accept & (dst == CH1);
    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;

    byte_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .wdata (in_data),
        .pop   (out0_ready),
        .rdata (out0_data),
        .full  (full0),
        .empty (empty0)
    );

    byte_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .wdata (in_data),
        .pop   (out1_ready),
        .rdata (out1_data),
        .full  (full1),
        .empty (empty1)
    );

    // Toggle advances only on bytes accepted in auto mode; counters track accepts per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl  <= 1'b0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (accept && auto_mode) begin
                tgl <= ~tgl;
            end
            if (push0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (push1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_byte_demux2.sv
// Self-checking bench for byte_demux2: directed scenarios plus randomized traffic against a queue model.
module tb_byte_demux2;

    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic       auto_mode;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int unsigned m_cnt0;
    int unsigned m_cnt1;
    bit          m_tgl;

    byte_demux2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .auto_mode  (auto_mode),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    function automatic bit model_dst();
        return auto_mode ? m_tgl : in_sel;
    endfunction

    function automatic bit model_ready();
        return model_dst() ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_tgl  = 1'b0;
    endtask

    // One clock: decide the model's transfers from current inputs, apply them at the edge.
    task automatic tick();
        bit dst, acc, p0, p1;
        dst = model_dst();
        acc = in_valid && model_ready();
        p0  = (q0.size() > 0) && out0_ready;
        p1  = (q1.size() > 0) && out1_ready;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (dst) begin
                q1.push_back(in_data);
                m_cnt1 = (m_cnt1 + 1) % 256;
            end else begin
                q0.push_back(in_data);
                m_cnt0 = (m_cnt0 + 1) % 256;
            end
            if (auto_mode) m_tgl = ~m_tgl;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_data = 8'h00; in_sel = 1'b0; in_valid = 1'b0;
        auto_mode = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        model_clear();
        #1;
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL reset_out0_valid got=%0b want=0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL reset_out1_valid got=%0b want=0", out1_valid); end
        checks++; if (out0_data !== 8'h00 || out1_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h/%h want=00/00", out0_data, out1_data); end
        checks++; if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt0, cnt1); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_basic();
        out0_ready = 1'b1; out1_ready = 1'b1; auto_mode = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA1;
        #1;
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL basic_no_flow_through got=%0b want=0", out0_valid); end
        tick();
        in_sel = 1'b1; in_data = 8'hB2;
        #1;
        checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hA1) begin failures++; $display("FAIL basic_out0 got=%0b/%h want=1/a1", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL basic_out1_early got=%0b want=0", out1_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out1_valid !== 1'b1 || out1_data !== 8'hB2) begin failures++; $display("FAIL basic_out1 got=%0b/%h want=1/b2", out1_valid, out1_data); end
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL basic_out0_popped got=%0b want=0", out0_valid); end
        checks++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin failures++; $display("FAIL basic_cnt got=%0d/%0d want=1/1", cnt0, cnt1); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] seq [3];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        out0_ready = 1'b0; out1_ready = 1'b1; auto_mode = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = seq[i];
            #1;
            checks++; if (in_ready !== (i < 2)) begin failures++; $display("FAIL bp_in_ready_%0d got=%0b want=%0b", i, in_ready, (i < 2)); end
            tick();
        end
        out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_no_bypass got=%0b want=0", in_ready); end
        checks++; if (out0_data !== 8'h11) begin failures++; $display("FAIL bp_head0 got=%h want=11", out0_data); end
        tick();
        #1;
        checks++; if (in_ready !== 1'b1 || out0_data !== 8'h22) begin failures++; $display("FAIL bp_head1 got=%0b/%h want=1/22", in_ready, out0_data); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h33) begin failures++; $display("FAIL bp_head2 got=%0b/%h want=1/33", out0_valid, out0_data); end
        tick();
        #1;
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b want=0", out0_valid); end
    endtask

    task automatic test_isolation();
        out0_ready = 1'b0; out1_ready = 1'b0; auto_mode = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        in_data = 8'h71; tick();
        in_data = 8'h72; tick();
        in_sel = 1'b1; in_data = 8'h5C;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL iso_in_ready got=%0b want=1", in_ready); end
        tick();
        in_valid = 1'b0; in_sel = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL iso_ch0_full got=%0b want=0", in_ready); end
        checks++; if (out0_data !== 8'h71 || out1_valid !== 1'b1 || out1_data !== 8'h5C) begin failures++; $display("FAIL iso_data got=%h/%0b/%h want=71/1/5c", out0_data, out1_valid, out1_data); end
        out0_ready = 1'b1;
        tick();
        #1;
        checks++; if (out0_data !== 8'h72) begin failures++; $display("FAIL iso_order got=%h want=72", out0_data); end
        out1_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_auto();
        out0_ready = 1'b0; out1_ready = 1'b0; auto_mode = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL auto_in_ready_%0d got=%0b want=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out0_data !== 8'h01 || out1_data !== 8'h02) begin failures++; $display("FAIL auto_first got=%h/%h want=01/02", out0_data, out1_data); end
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        #1;
        checks++; if (out0_data !== 8'h03 || out1_data !== 8'h04) begin failures++; $display("FAIL auto_second got=%h/%h want=03/04", out0_data, out1_data); end
        tick();
        auto_mode = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failures++; $display("FAIL auto_drained got=%0b/%0b want=0/0", out0_valid, out1_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        auto_mode = 1'b0; in_sel = 1'b1; in_valid = 1'b1;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'($urandom);
            tick();
            if (i == 254) begin
                checks++; if (cnt1 !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d want=255", cnt1); end
            end
        end
        in_valid = 1'b0;
        #1;
        checks++; if (cnt1 !== 8'd0 || cnt0 !== 8'd0) begin failures++; $display("FAIL wrap_cnt got=%0d/%0d want=0/0", cnt1, cnt0); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        out0_ready = 1'b0; out1_ready = 1'b0; auto_mode = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        in_data = 8'h91; tick();
        in_data = 8'h92; tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (out0_valid !== 1'b0 || out0_data !== 8'h00) begin failures++; $display("FAIL rmid_out0 got=%0b/%h want=0/00", out0_valid, out0_data); end
        checks++; if (cnt0 !== 8'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmid_cnt_ready got=%0d/%0b want=0/1", cnt0, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL rmid_ghost_%0d got=%0b want=0", i, out0_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = 1'($urandom);
            in_data    = 8'($urandom);
            out0_ready = ($urandom_range(0, 2) == 0);
            out1_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) auto_mode = ~auto_mode;
            #1;
            checks++; if (in_ready !== model_ready()) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b want=%0b", i, in_ready, model_ready()); end
            checks++; if (out0_valid !== (q0.size() > 0) || out1_valid !== (q1.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b/%0b want=%0b/%0b", i, out0_valid, out1_valid, q0.size() > 0, q1.size() > 0); end
            if (q0.size() > 0) begin
                checks++; if (out0_data !== q0[0]) begin failures++; $display("FAIL rnd_out0 cyc=%0d got=%h want=%h", i, out0_data, q0[0]); end
            end
            if (q1.size() > 0) begin
                checks++; if (out1_data !== q1[0]) begin failures++; $display("FAIL rnd_out1 cyc=%0d got=%h want=%h", i, out1_data, q1[0]); end
            end
            checks++; if (cnt0 !== 8'(m_cnt0) || cnt1 !== 8'(m_cnt1)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, cnt0, cnt1, m_cnt0, m_cnt1); end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_isolation();
        test_auto();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
